// File: rtl/qysys_test_mem_tester.sv
// qysys_test_mem_tester
// Avalon-MM master for the 1024 x 32 on-chip memory. On start it writes a
// selected pattern to every word, reads every word back, and compares each
// returned word against the regenerated pattern.
//
// Ports
//   clk, reset_n        : clock, asynchronous active-low reset
//   start, abort        : test request (accepted in IDLE only) / synchronous stop
//   pattern_sel, seed   : 0 addr, 1 ~addr, 2 constant seed, 3 LFSR seeded by seed
//   busy, done, pass    : status; done is a one-cycle pulse, pass valid from done
//   err_count           : mismatching words, saturating
//   first_err_addr      : address of the first mismatch, 0 if none
//   address, byteenable, chipselect, write, writedata, clken : Avalon master side
//   readdata            : Avalon read data, sampled READ_LATENCY cycles after
//                         the slave captures the read
module qysys_test_mem_tester #(
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        pattern_sel,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  output logic              clken,
  input  logic [31:0]       readdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  // One extra stage covers the slave's own capture edge before its latency starts.
  localparam int                PIPE       = READ_LATENCY + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [2:0]        DRAIN_LAST = 3'(READ_LATENCY - 1);
  localparam logic [31:0]       LFSR_TAPS  = 32'h80200003;

  function automatic logic [31:0] lfsr_init(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  // A set lsb folds the taps into the word; a clear lsb shifts right.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? (v ^ LFSR_TAPS) : (v >> 1);
  endfunction

  function automatic logic [31:0] pattern_word(input logic [1:0]        sel,
                                               input logic [31:0]       s,
                                               input logic [ADDR_W-1:0] a,
                                               input logic [31:0]       lfsr);
    logic [31:0] a_ext;
    a_ext = 32'(a);
    case (sel)
      2'd0:    return a_ext;
      2'd1:    return ~a_ext;
      2'd2:    return s;
      default: return lfsr;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  state_t            state, next_state;
  logic [1:0]        sel_q;
  logic [31:0]       seed_q;
  logic [31:0]       lfsr_q;
  logic [2:0]        drain_cnt;

  logic              accept, restart, advance;
  logic [1:0]        sel_use;
  logic [31:0]       seed_use;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       lfsr_d;
  logic [31:0]       word_d;
  logic              cs_d, wr_d, rd_d;

  logic [PIPE-1:0]   vld_p;
  logic [31:0]       exp_p [PIPE];
  logic [ADDR_W-1:0] ea_p  [PIPE];

  logic              mismatch;
  logic [15:0]       err_next;
  logic [ADDR_W-1:0] first_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start && !abort) next_state = S_WRITE;
      S_WRITE: if (abort) next_state = S_IDLE;
               else if (address == LAST_ADDR) next_state = S_READ;
      S_READ:  if (abort) next_state = S_IDLE;
               else if (address == LAST_ADDR) next_state = S_DRAIN;
      S_DRAIN: if (abort) next_state = S_IDLE;
               else if (drain_cnt == DRAIN_LAST) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Next values of the registered Avalon outputs. The generator restarts at
  // test start and again at READ entry, so reads regenerate the written words.
  always_comb begin
    accept   = (state == S_IDLE) && (next_state == S_WRITE);
    restart  = accept || ((state == S_WRITE) && (next_state == S_READ));
    advance  = ((state == S_WRITE) && (next_state == S_WRITE)) ||
               ((state == S_READ)  && (next_state == S_READ));
    sel_use  = accept ? pattern_sel : sel_q;
    seed_use = accept ? seed : seed_q;
    addr_d   = '0;
    lfsr_d   = lfsr_q;
    if (restart) begin
      lfsr_d = lfsr_init(seed_use);
    end else if (advance) begin
      addr_d = address + 1'b1;
      lfsr_d = lfsr_step(lfsr_q);
    end
    word_d = pattern_word(sel_use, seed_use, addr_d, lfsr_d);
    cs_d   = restart || advance;
    wr_d   = cs_d && (next_state == S_WRITE);
    rd_d   = cs_d && (next_state == S_READ);
  end

  // Compare stage: the oldest expected entry meets readdata.
  always_comb begin
    mismatch   = vld_p[PIPE-1] && (readdata != exp_p[PIPE-1]);
    err_next   = mismatch ? sat_inc(err_count) : err_count;
    first_next = (mismatch && (err_count == 16'h0)) ? ea_p[PIPE-1] : first_err_addr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      address        <= '0;
      byteenable     <= 4'h0;
      chipselect     <= 1'b0;
      write          <= 1'b0;
      writedata      <= '0;
      clken          <= 1'b1;
      drain_cnt      <= '0;
      vld_p          <= '0;
    end else begin
      busy       <= (next_state == S_WRITE) || (next_state == S_READ) ||
                    (next_state == S_DRAIN);
      done       <= (next_state == S_DONE);
      address    <= addr_d;
      chipselect <= cs_d;
      byteenable <= cs_d ? 4'hF : 4'h0;
      write      <= wr_d;
      writedata  <= wr_d ? word_d : 32'h0;
      clken      <= 1'b1;
      drain_cnt  <= (state == S_DRAIN) ? drain_cnt + 3'd1 : 3'd0;
      // An abort drops any reads still in flight.
      if (abort) vld_p <= '0;
      else       vld_p <= {vld_p[PIPE-2:0], rd_d};
      if (accept) begin
        err_count      <= '0;
        first_err_addr <= '0;
        pass           <= 1'b0;
      end else if (!abort) begin
        err_count      <= err_next;
        first_err_addr <= first_next;
        if (next_state == S_DONE) pass <= (err_next == 16'h0);
      end
    end
  end

  // Expected-word pipeline stage 0 is loaded alongside the read address.
  always_ff @(posedge clk) begin
    lfsr_q <= lfsr_d;
    if (accept) begin
      sel_q  <= pattern_sel;
      seed_q <= seed;
    end
    exp_p[0] <= word_d;
    ea_p[0]  <= addr_d;
    for (int i = 1; i < PIPE; i++) begin
      exp_p[i] <= exp_p[i-1];
      ea_p[i]  <= ea_p[i-1];
    end
  end

endmodule

// File: tb/tb_qysys_test_mem_tester.sv
// Bench for qysys_test_mem_tester: two instances (read latency 1 and 3), each
// with its own behavioural 1024 x 32 memory. Written words and completion
// results are queued when a test is started and retired as the DUTs produce them.
module tb_qysys_test_mem_tester;

  localparam int DEPTH = 1024;

  typedef struct {
    logic        pass;
    logic [15:0] err;
    logic [9:0]  fea;
  } res_t;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [1:0]  pattern_sel;
  logic [31:0] seed;

  logic        busy_a, done_a, pass_a, cs_a, write_a, clken_a;
  logic [15:0] err_a;
  logic [9:0]  fea_a, address_a;
  logic [3:0]  be_a;
  logic [31:0] wdata_a, readdata_a;

  logic        busy_b, done_b, pass_b, cs_b, write_b, clken_b;
  logic [15:0] err_b;
  logic [9:0]  fea_b, address_b;
  logic [3:0]  be_b;
  logic [31:0] wdata_b, readdata_b;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   start_cyc = 0;
  int   mlat_b   = 3;
  logic fault_en = 1'b0;
  logic [31:0] w0, w1, w2;

  res_t rq_a[$], rq_b[$];
  wr_t  wq_a[$], wq_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qysys_test_mem_tester #(.DEPTH(DEPTH), .ADDR_W(10), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .pattern_sel(pattern_sel), .seed(seed),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_err_addr(fea_a), .address(address_a), .byteenable(be_a),
    .chipselect(cs_a), .write(write_a), .writedata(wdata_a), .clken(clken_a),
    .readdata(readdata_a)
  );

  qysys_test_mem_tester #(.DEPTH(DEPTH), .ADDR_W(10), .READ_LATENCY(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .pattern_sel(pattern_sel), .seed(seed),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_err_addr(fea_b), .address(address_b), .byteenable(be_b),
    .chipselect(cs_b), .write(write_b), .writedata(wdata_b), .clken(clken_b),
    .readdata(readdata_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory models: capture at the edge, data returned mlat cycles later.
  function automatic logic [31:0] rd_fault(input logic [31:0] d, input logic [9:0] a);
    logic [31:0] r;
    r = d;
    if (fault_en && (a >= 10'd16) && (a <= 10'd19)) r[5] = 1'b1;
    return r;
  endfunction

  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];
  logic [31:0] dl_a [4];
  logic [31:0] dl_b [4];

  always @(posedge clk) begin
    if (cs_a && write_a) mem_a[address_a] <= wdata_a;
    dl_a[0] <= (cs_a && !write_a) ? rd_fault(mem_a[address_a], address_a) : 32'h0;
    for (int i = 1; i < 4; i++) dl_a[i] <= dl_a[i-1];
  end
  assign readdata_a = dl_a[0];

  always @(posedge clk) begin
    if (cs_b && write_b) mem_b[address_b] <= wdata_b;
    dl_b[0] <= (cs_b && !write_b) ? rd_fault(mem_b[address_b], address_b) : 32'h0;
    for (int j = 1; j < 4; j++) dl_b[j] <= dl_b[j-1];
  end
  assign readdata_b = dl_b[mlat_b-1];

  // Write scoreboards
  always @(negedge clk) begin : mon_wr_a
    wr_t e;
    if (reset_n && cs_a && write_a) begin
      if (address_a == 10'd0) w0 = wdata_a;
      if (address_a == 10'd1) w1 = wdata_a;
      if (address_a == 10'd2) w2 = wdata_a;
      if (wq_a.size() == 0) check_eq("a_wr_extra", 1, 0);
      else begin
        e = wq_a.pop_front();
        check_eq("a_wr", {be_a, address_a, wdata_a}, {4'hF, e.a, e.d});
      end
    end
  end

  always @(negedge clk) begin : mon_wr_b
    wr_t e;
    if (reset_n && cs_b && write_b) begin
      if (wq_b.size() == 0) check_eq("b_wr_extra", 1, 0);
      else begin
        e = wq_b.pop_front();
        check_eq("b_wr", {be_b, address_b, wdata_b}, {4'hF, e.a, e.d});
      end
    end
  end

  // Completion scoreboards; cycle 1 is the cycle right after the start edge.
  always @(negedge clk) begin : mon_done_a
    res_t r;
    if (reset_n && done_a) begin
      if (rq_a.size() == 0) check_eq("a_done_extra", 1, 0);
      else begin
        r = rq_a.pop_front();
        check_eq("a_done_cycle", cyc - start_cyc + 1, 2 * DEPTH + 1 + 1);
        check_eq("a_pass", pass_a, r.pass);
        check_eq("a_err_count", err_a, r.err);
        check_eq("a_first_err", fea_a, r.fea);
      end
    end
  end

  always @(negedge clk) begin : mon_done_b
    res_t r;
    if (reset_n && done_b) begin
      if (rq_b.size() == 0) check_eq("b_done_extra", 1, 0);
      else begin
        r = rq_b.pop_front();
        check_eq("b_done_cycle", cyc - start_cyc + 1, 2 * DEPTH + 3 + 1);
        check_eq("b_pass", pass_b, r.pass);
        check_eq("b_err_count", err_b, r.err);
        check_eq("b_first_err", fea_b, r.fea);
      end
    end
  end

  function automatic res_t mk(input logic p, input logic [15:0] e, input logic [9:0] f);
    res_t r;
    r.pass = p;
    r.err  = e;
    r.fea  = f;
    return r;
  endfunction

  function automatic logic [31:0] ref_step(input logic [31:0] v);
    return v[0] ? (v ^ 32'h80200003) : (v >> 1);
  endfunction

  task automatic push_writes(input logic [1:0] sel, input logic [31:0] sd);
    logic [31:0] lf;
    wr_t e;
    lf = (sd == 32'h0) ? 32'h1 : sd;
    for (int n = 0; n < DEPTH; n++) begin
      e.a = 10'(n);
      case (sel)
        2'd0:    e.d = 32'(n);
        2'd1:    e.d = ~(32'(n));
        2'd2:    e.d = sd;
        default: e.d = lf;
      endcase
      wq_a.push_back(e);
      wq_b.push_back(e);
      lf = ref_step(lf);
    end
  endtask

  task automatic pulse_start(input logic [1:0] sel, input logic [31:0] sd);
    @(negedge clk);
    pattern_sel = sel;
    seed        = sd;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start     = 1'b0;
  endtask

  task automatic run(input logic [1:0] sel, input logic [31:0] sd,
                     input res_t ea, input res_t eb, input int repulse);
    int n;
    push_writes(sel, sd);
    rq_a.push_back(ea);
    rq_b.push_back(eb);
    pulse_start(sel, sd);
    n = 0;
    while ((rq_a.size() != 0 || rq_b.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
      start = (n == repulse);
    end
    start = 1'b0;
    check_eq("run_complete", n < 3000, 1);
    repeat (10) @(negedge clk);
    check_eq("wq_left", {wq_a.size(), wq_b.size()}, 0);
    check_eq("idle_busy", {busy_a, busy_b, cs_a, cs_b}, 0);
  endtask

  task automatic check_reset_vals();
    check_eq("a_rst_ctl", {busy_a, done_a, pass_a, cs_a, write_a, be_a, clken_a}, 10'h001);
    check_eq("a_rst_stats", {err_a, fea_a}, 0);
    check_eq("a_rst_bus", {address_a, wdata_a}, 0);
    check_eq("b_rst_ctl", {busy_b, done_b, pass_b, cs_b, write_b, be_b, clken_b}, 10'h001);
    check_eq("b_rst_stats", {err_b, fea_b}, 0);
    check_eq("b_rst_bus", {address_b, wdata_b}, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    pattern_sel = 2'd0;
    seed        = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // address pattern, clean memories
    run(2'd0, 32'h0, mk(1'b1, 16'd0, 10'd0), mk(1'b1, 16'd0, 10'd0), 0);

    // LFSR from seed 0
    run(2'd3, 32'h0, mk(1'b1, 16'd0, 10'd0), mk(1'b1, 16'd0, 10'd0), 0);
    check_eq("lfsr_w0", w0, 32'h00000001);
    check_eq("lfsr_w1", w1, 32'h80200002);
    check_eq("lfsr_w2", w2, 32'h40100001);

    // bit 5 stuck at 1 on addresses 16..19, constant zero pattern
    fault_en = 1'b1;
    run(2'd2, 32'h0, mk(1'b0, 16'd4, 10'd16), mk(1'b0, 16'd4, 10'd16), 0);
    fault_en = 1'b0;

    // latency-3 tester against a latency-2 memory: each compare sees the next word
    mlat_b = 2;
    run(2'd0, 32'h0, mk(1'b1, 16'd0, 10'd0), mk(1'b0, 16'd1024, 10'd0), 0);
    mlat_b = 3;

    // inverted address, start re-pulsed mid-test
    run(2'd1, 32'h0, mk(1'b1, 16'd0, 10'd0), mk(1'b1, 16'd0, 10'd0), 100);

    // abort during the read phase
    push_writes(2'd0, 32'h0);
    pulse_start(2'd0, 32'h0);
    repeat (1499) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check_eq("abort_busy", {busy_a, busy_b}, 0);
    check_eq("abort_stats", {pass_a, err_a, pass_b, err_b}, 0);
    repeat (1000) @(negedge clk);
    check_eq("abort_wq_left", {wq_a.size(), wq_b.size()}, 0);
    check_eq("abort_no_done_pending", {rq_a.size(), rq_b.size()}, 0);

    // abort wins over start in the same idle cycle
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check_eq("abort_start_busy", {busy_a, busy_b, cs_a, cs_b}, 0);
    @(negedge clk);
    check_eq("abort_start_busy2", {busy_a, busy_b}, 0);

    // reset_n pulled low mid-test
    push_writes(2'd0, 32'h0);
    rq_a.push_back(mk(1'b1, 16'd0, 10'd0));
    rq_b.push_back(mk(1'b1, 16'd0, 10'd0));
    pulse_start(2'd0, 32'h0);
    repeat (699) @(posedge clk);
    #2;
    check_eq("pre_reset_busy", {busy_a, busy_b}, 2'b11);
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    wq_a.delete();
    wq_b.delete();
    rq_a.delete();
    rq_b.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_busy", {busy_a, busy_b}, 0);

    run(2'd3, 32'hDEADBEEF, mk(1'b1, 16'd0, 10'd0), mk(1'b1, 16'd0, 10'd0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
